// File: rtl/bnn_img_loader.sv
// Byte-stream image loader and result hand-off for the BNN inference wrapper.
// Optional inference watchdog enabled by defining BNN_TIMEOUT_EN.
module bnn_img_loader #(
    parameter int unsigned IMG_BITS       = 904,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                abort,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic                bnn_enable,
    input  logic [3:0]          bnn_result,
    input  logic                bnn_result_ready,
    output logic                bnn_clear,
    output logic [3:0]          result_data,
    output logic                result_valid,
    input  logic                result_ack,
    output logic [6:0]          byte_count,
    output logic                timeout_err
);

    localparam int unsigned NUM_BYTES = IMG_BITS / 8;
    localparam int unsigned IW        = $clog2(IMG_BITS);

    if ((IMG_BITS % 8) != 0 || NUM_BYTES > 127) begin : g_bad_img_bits
        $error("bnn_img_loader: IMG_BITS must be a multiple of 8 with at most 127 bytes");
    end
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 131072) begin : g_bad_timeout
        $error("bnn_img_loader: TIMEOUT_CYCLES must be in 1..131072");
    end

    typedef enum logic [1:0] {
        S_FILL,
        S_WAIT_RESULT,
        S_PRESENT,
        S_CLEAR
    } state_t;

    state_t                r_state;
    logic                  r_rx_ready;
    logic [IMG_BITS-1:0]   r_img;
    logic                  r_img_full;
    logic                  r_bnn_enable;
    logic                  r_bnn_clear;
    logic [3:0]            r_result_data;
    logic                  r_result_valid;
    logic [6:0]            r_byte_count;

    logic                  w_accept;
    logic                  w_last;
    logic [IW-1:0]         w_lo;
    logic                  w_tmo_hit;

    // rx_ready is only high in FILL, so acceptance needs no state decode.
    assign w_accept = rx_valid & r_rx_ready & ~abort;
    assign w_last   = (r_byte_count == 7'(NUM_BYTES - 1));
    assign w_lo     = IW'(IMG_BITS - 8) - IW'({r_byte_count, 3'b000});

`ifdef BNN_TIMEOUT_EN
    logic [16:0] r_tmo_cnt;
    logic        r_timeout_err;

    assign w_tmo_hit   = (r_tmo_cnt == 17'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT_RESULT) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 17'd1;
        end
    end

    // Abort and a same-cycle result both take precedence over the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == S_WAIT_RESULT && w_tmo_hit && !abort && !bnn_result_ready) begin
            r_timeout_err <= 1'b1;
        end else if (w_accept && r_byte_count == 7'd0) begin
            r_timeout_err <= 1'b0;
        end
    end
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FILL;
            r_rx_ready     <= 1'b1;
            r_img          <= '0;
            r_img_full     <= 1'b0;
            r_bnn_enable   <= 1'b0;
            r_bnn_clear    <= 1'b0;
            r_result_data  <= '0;
            r_result_valid <= 1'b0;
            r_byte_count   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (abort) begin
                        r_byte_count <= '0;
                        r_img        <= '0;
                    end else if (w_accept) begin
                        r_img[w_lo +: 8] <= rx_data;
                        r_byte_count     <= r_byte_count + 7'd1;
                        if (w_last) begin
                            r_state      <= S_WAIT_RESULT;
                            r_rx_ready   <= 1'b0;
                            r_img_full   <= 1'b1;
                            r_bnn_enable <= 1'b1;
                        end
                    end
                end
                S_WAIT_RESULT: begin
                    if (abort || (!bnn_result_ready && w_tmo_hit)) begin
                        r_img_full   <= 1'b0;
                        r_bnn_enable <= 1'b0;
                        r_bnn_clear  <= 1'b1;
                        r_state      <= S_CLEAR;
                    end else if (bnn_result_ready) begin
                        r_result_data  <= bnn_result;
                        r_result_valid <= 1'b1;
                        r_img_full     <= 1'b0;
                        r_bnn_enable   <= 1'b0;
                        r_state        <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (abort || result_ack) begin
                        r_result_valid <= 1'b0;
                        r_bnn_clear    <= 1'b1;
                        r_state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_bnn_clear  <= 1'b0;
                    r_byte_count <= '0;
                    r_img        <= '0;
                    r_rx_ready   <= 1'b1;
                    r_state      <= S_FILL;
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign rx_ready        = r_rx_ready;
    assign img_out         = r_img;
    assign img_buffer_full = r_img_full;
    assign bnn_enable      = r_bnn_enable;
    assign bnn_clear       = r_bnn_clear;
    assign result_data     = r_result_data;
    assign result_valid    = r_result_valid;
    assign byte_count      = r_byte_count;

endmodule

// File: tb/tb_bnn_img_loader.sv
// Self-checking bench for bnn_img_loader: vector table, directed corner cases,
// and randomized image/result rounds against a byte-queue reference model.
module tb_bnn_img_loader;

    localparam int IMG_BITS = 904;
    localparam int NB       = 113;
    localparam int TMO      = 100;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                abort;
    logic [IMG_BITS-1:0] img_out;
    logic                img_buffer_full;
    logic                bnn_enable;
    logic [3:0]          bnn_result;
    logic                bnn_result_ready;
    logic                bnn_clear;
    logic [3:0]          result_data;
    logic                result_valid;
    logic                result_ack;
    logic [6:0]          byte_count;
    logic                timeout_err;

    always #5 clk = ~clk;

    bnn_img_loader #(
        .IMG_BITS       (IMG_BITS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .abort            (abort),
        .img_out          (img_out),
        .img_buffer_full  (img_buffer_full),
        .bnn_enable       (bnn_enable),
        .bnn_result       (bnn_result),
        .bnn_result_ready (bnn_result_ready),
        .bnn_clear        (bnn_clear),
        .result_data      (result_data),
        .result_valid     (result_valid),
        .result_ack       (result_ack),
        .byte_count       (byte_count),
        .timeout_err      (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;
    logic [7:0] model_q[$];

    always @(negedge clk) if (bnn_clear === 1'b1) clr_pulses++;

    typedef struct {
        logic       v;
        logic       ab;
        logic [7:0] d;
        logic [6:0] cnt;
        logic       rdy;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Byte k of the stream occupies bits [IMG_BITS-1-8k -: 8]; unsent bytes are zero.
    function automatic logic [IMG_BITS-1:0] model_img();
        logic [IMG_BITS-1:0] v;
        v = '0;
        for (int k = 0; k < model_q.size(); k++) v[IMG_BITS-1-8*k -: 8] = model_q[k];
        return v;
    endfunction

    task automatic chk_img(input string name);
        logic [IMG_BITS-1:0] e;
        e = model_img();
        checks++;
        if (img_out !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, img_out, e);
        end
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            model_q.push_back(rx_data);
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_q.delete();
    endtask

    task automatic chk_full_image();
        chk("full_ibf", img_buffer_full, 1);
        chk("full_en", bnn_enable, 1);
        chk("full_rdy", rx_ready, 0);
        chk("full_cnt", byte_count, NB);
        chk_img("full_img");
    endtask

    task automatic deliver(input int delay, input logic [3:0] res, input int ack_delay);
        int c0;
        for (int i = 0; i < delay; i++) begin
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            result_ack = 1'($urandom);
            tick();
        end
        result_ack = 1'b0;
        chk("wait_rdy", rx_ready, 0);
        chk("wait_cnt", byte_count, NB);
        chk("wait_ibf", img_buffer_full, 1);
        chk("wait_rv", result_valid, 0);
        chk_img("wait_img");
        bnn_result = res;
        bnn_result_ready = 1'b1;
        tick();
        chk("pres_rv", result_valid, 1);
        chk("pres_rd", result_data, res);
        chk("pres_ibf", img_buffer_full, 0);
        chk("pres_en", bnn_enable, 0);
        bnn_result = 4'($urandom);
        for (int i = 0; i < ack_delay; i++) begin
            rx_valid = 1'($urandom);
            tick();
        end
        chk("hold_rv", result_valid, 1);
        chk("hold_rd", result_data, res);
        chk("hold_cnt", byte_count, NB);
        rx_valid = 1'b0;
        c0 = clr_pulses;
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_rv", result_valid, 0);
        chk("ack_clr", bnn_clear, 1);
        bnn_result_ready = 1'b0;
        tick();
        model_q.delete();
        chk("clr_done", bnn_clear, 0);
        chk("clr_rdy", rx_ready, 1);
        chk("clr_cnt", byte_count, 0);
        chk("clr_pulses", clr_pulses - c0, 1);
        chk_img("clr_img");
    endtask

    initial begin
        int c0;
        vecs[0] = '{1'b1, 1'b0, 8'hA5, 7'd1, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 8'h77, 7'd1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h3C, 7'd2, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 7'd0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 7'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'h11, 7'd1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'h99, 7'd0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 8'h22, 7'd1, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h33, 7'd2, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 7'd3, 1'b1};

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; abort = 1'b0;
        bnn_result = '0; bnn_result_ready = 1'b0; result_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rdy", rx_ready, 1);
        chk("rst_cnt", byte_count, 0);
        chk("rst_ibf", img_buffer_full, 0);
        chk("rst_en", bnn_enable, 0);
        chk("rst_clr", bnn_clear, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_rd", result_data, 0);
        chk("rst_tmo", timeout_err, 0);
        chk_img("rst_img");

        for (int i = 0; i < 10; i++) begin
            rx_valid = vecs[i].v;
            abort    = vecs[i].ab;
            rx_data  = vecs[i].d;
            tick();
            if (vecs[i].ab) model_q.delete();
            else if (vecs[i].v) model_q.push_back(vecs[i].d);
            chk("vec_cnt", byte_count, vecs[i].cnt);
            chk("vec_rdy", rx_ready, vecs[i].rdy);
        end
        rx_valid = 1'b0; abort = 1'b0;
        chk_img("vec_img");

        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_ign_rv", result_valid, 0);
        chk("ack_ign_cnt", byte_count, 3);
        chk("ack_ign_clr", bnn_clear, 0);
        do_abort();
        chk("abort_cnt", byte_count, 0);
        chk_img("abort_img");

        // Incrementing stream 0x00..0x70; img_buffer_full one cycle after the last byte.
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) begin
                chk("pre_last_ibf", img_buffer_full, 0);
                chk("pre_last_cnt", byte_count, NB - 1);
            end
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            model_q.push_back(rx_data);
            tick();
        end
        rx_valid = 1'b0;
        chk_full_image();
        chk("inc_top", img_out[IMG_BITS-1 -: 8], 8'h00);
        chk("inc_bot", img_out[7:0], 8'h70);
        deliver(40, 4'd7, 3);

        // Abort after 50 bytes, then a fresh image.
        send_random(50);
        chk("part_cnt", byte_count, 50);
        chk_img("part_img");
        do_abort();
        chk("ab50_cnt", byte_count, 0);
        chk_img("ab50_img");
        send_random(NB);
        chk_full_image();

        // Abort together with result_ready: no result, one clear pulse.
        c0 = clr_pulses;
        abort = 1'b1;
        bnn_result = 4'd5;
        bnn_result_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("abres_rv", result_valid, 0);
        chk("abres_clr", bnn_clear, 1);
        chk("abres_ibf", img_buffer_full, 0);
        bnn_result_ready = 1'b0;
        tick();
        model_q.delete();
        chk("abres_rv2", result_valid, 0);
        chk("abres_rdy", rx_ready, 1);
        chk("abres_cnt", byte_count, 0);
        chk("abres_pulses", clr_pulses - c0, 1);

        // Abort in PRESENT.
        send_random(NB);
        bnn_result = 4'd2;
        bnn_result_ready = 1'b1;
        tick();
        chk("abp_rv", result_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abp_rv0", result_valid, 0);
        chk("abp_clr", bnn_clear, 1);
        bnn_result_ready = 1'b0;
        tick();
        model_q.delete();
        chk("abp_rdy", rx_ready, 1);
        chk("abp_clr0", bnn_clear, 0);

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_random($urandom_range(1, NB - 1));
                do_abort();
                chk("rnd_ab_cnt", byte_count, 0);
            end
            send_random(NB);
            chk_full_image();
            deliver($urandom_range(1, 30), 4'($urandom_range(0, 15)), $urandom_range(0, 5));
        end

        // Watchdog.
        send_random(NB);
        chk_full_image();
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo_pre_ibf", img_buffer_full, 1);
        chk("tmo_pre_err", timeout_err, 0);
        c0 = clr_pulses;
        tick();
`ifdef BNN_TIMEOUT_EN
        chk("tmo_err", timeout_err, 1);
        chk("tmo_clr", bnn_clear, 1);
        chk("tmo_ibf", img_buffer_full, 0);
        tick();
        model_q.delete();
        chk("tmo_rdy", rx_ready, 1);
        chk("tmo_cnt", byte_count, 0);
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_pulses", clr_pulses - c0, 1);
        send_random(1);
        chk("tmo_cleared", timeout_err, 0);
        do_abort();
`else
        for (int i = 0; i < 50; i++) tick();
        chk("notmo_err", timeout_err, 0);
        chk("notmo_ibf", img_buffer_full, 1);
        chk("notmo_clr", clr_pulses - c0, 0);
        chk("notmo_rdy", rx_ready, 0);
        deliver(1, 4'd12, 1);
`endif

        // Reset in PRESENT: immediate return to reset values, no clear pulse.
        send_random(NB);
        bnn_result = 4'd9;
        bnn_result_ready = 1'b1;
        tick();
        chk("mrst_pre_rv", result_valid, 1);
        c0 = clr_pulses;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bnn_result_ready = 1'b0;
        model_q.delete();
        chk("mrst_rv", result_valid, 0);
        chk("mrst_rd", result_data, 0);
        chk("mrst_rdy", rx_ready, 1);
        chk("mrst_cnt", byte_count, 0);
        chk("mrst_ibf", img_buffer_full, 0);
        chk_img("mrst_img");
        tick();
        chk("mrst_pulses", clr_pulses - c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
